// File: rtl/dual_port_ram_arbiter.sv
// Shares one dual-port RAM (A: read/write, B: read-only) between two clients with
// round-robin write arbitration, same-address RAW deferral and fixed-latency read return.
module dual_port_ram_arbiter #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clockPulse,
    input  logic                  resetN,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  grant0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  grant1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ramWriteEnable,
    output logic [ADDR_WIDTH-1:0] ramAddrA,
    output logic [ADDR_WIDTH-1:0] ramAddrB,
    output logic [DATA_WIDTH-1:0] ramWriteData,
    input  logic [DATA_WIDTH-1:0] ramDataA,
    input  logic [DATA_WIDTH-1:0] ramDataB
);
    localparam int PIPE_W = READ_LATENCY + 1;

    logic [1:0]                  req_c, we_c;
    logic [ADDR_WIDTH-1:0]       addr_c [2];
    logic [DATA_WIDTH-1:0]       wdata_c [2];

    logic [1:0]                  grant_q, grant_d;
    logic                        rr_ptr_q, rr_ptr_d;
    logic                        ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]       ram_addr_a_q, ram_addr_a_d;
    logic [ADDR_WIDTH-1:0]       ram_addr_b_q, ram_addr_b_d;
    logic [DATA_WIDTH-1:0]       ram_wdata_q, ram_wdata_d;

    logic [1:0]                  elig, issue, rd_issue, wr_issue, rd_on_b;
    logic [1:0]                  rvalid_c;
    logic [1:0][DATA_WIDTH-1:0]  rdata_c;

    assign req_c      = {req1, req0};
    assign we_c       = {we1, we0};
    assign addr_c[0]  = addr0;
    assign addr_c[1]  = addr1;
    assign wdata_c[0] = wdata0;
    assign wdata_c[1] = wdata1;

    // A client granted in the current cycle sits out the next sampling edge.
    always_comb begin : arbitrate
        elig     = req_c & ~grant_q;
        issue    = elig;
        rr_ptr_d = rr_ptr_q;
        if (&elig) begin
            if (&we_c) begin
                issue    = rr_ptr_q ? 2'b10 : 2'b01;
                rr_ptr_d = ~rr_ptr_q;
            end else if ((we_c[0] ^ we_c[1]) && (addr_c[0] == addr_c[1])) begin
                issue    = we_c;
                rr_ptr_d = we_c[0];
            end
        end
    end

    assign rd_issue = issue & ~we_c;
    assign wr_issue = issue & we_c;
    assign grant_d  = issue;

    // Port A is taken by a write if there is one; a lone read otherwise uses A.
    always_comb begin : ram_ctrl
        ram_we_d     = 1'b0;
        ram_addr_a_d = ram_addr_a_q;
        ram_addr_b_d = ram_addr_b_q;
        ram_wdata_d  = ram_wdata_q;
        rd_on_b      = 2'b00;
        if (wr_issue[0]) begin
            ram_we_d     = 1'b1;
            ram_addr_a_d = addr_c[0];
            ram_wdata_d  = wdata_c[0];
        end else if (wr_issue[1]) begin
            ram_we_d     = 1'b1;
            ram_addr_a_d = addr_c[1];
            ram_wdata_d  = wdata_c[1];
        end
        if (&rd_issue) begin
            ram_addr_a_d = addr_c[0];
            ram_addr_b_d = addr_c[1];
            rd_on_b      = 2'b10;
        end else if (rd_issue[0]) begin
            if (|wr_issue) begin
                ram_addr_b_d = addr_c[0];
                rd_on_b[0]   = 1'b1;
            end else begin
                ram_addr_a_d = addr_c[0];
            end
        end else if (rd_issue[1]) begin
            if (|wr_issue) begin
                ram_addr_b_d = addr_c[1];
                rd_on_b[1]   = 1'b1;
            end else begin
                ram_addr_a_d = addr_c[1];
            end
        end
    end

    always_ff @(posedge clockPulse or negedge resetN) begin
        if (!resetN) begin
            grant_q      <= '0;
            rr_ptr_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_a_q <= '0;
            ram_addr_b_q <= '0;
            ram_wdata_q  <= '0;
        end else begin
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            ram_we_q     <= ram_we_d;
            ram_addr_a_q <= ram_addr_a_d;
            ram_addr_b_q <= ram_addr_b_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Per-client return pipe: tracks issued reads and which port will deliver the data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_return
        logic [PIPE_W-1:0]     pend_q, pend_d;
        logic [PIPE_W-1:0]     on_b_q, on_b_d;
        logic                  rvalid_q, rvalid_d;
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            pend_d   = {pend_q[PIPE_W-2:0], rd_issue[gi]};
            on_b_d   = {on_b_q[PIPE_W-2:0], rd_on_b[gi]};
            rvalid_d = pend_q[PIPE_W-1];
            rdata_d  = rdata_q;
            if (pend_q[PIPE_W-1]) begin
                rdata_d = on_b_q[PIPE_W-1] ? ramDataB : ramDataA;
            end
        end

        always_ff @(posedge clockPulse or negedge resetN) begin
            if (!resetN) begin
                pend_q   <= '0;
                on_b_q   <= '0;
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                pend_q   <= pend_d;
                on_b_q   <= on_b_d;
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end

        assign rvalid_c[gi] = rvalid_q;
        assign rdata_c[gi]  = rdata_q;
    end

    assign grant0         = grant_q[0];
    assign grant1         = grant_q[1];
    assign rvalid0        = rvalid_c[0];
    assign rvalid1        = rvalid_c[1];
    assign rdata0         = rdata_c[0];
    assign rdata1         = rdata_c[1];
    assign ramWriteEnable = ram_we_q;
    assign ramAddrA       = ram_addr_a_q;
    assign ramAddrB       = ram_addr_b_q;
    assign ramWriteData   = ram_wdata_q;
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter: RAM macro model, reference-memory scoreboard,
// vector table, directed corner sequences and randomized traffic.
module tb_dual_port_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int RL = 1;

    logic          clockPulse = 1'b0;
    logic          resetN = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          grant0, rvalid0, grant1, rvalid1, ramWriteEnable;
    logic [DW-1:0] rdata0, rdata1, ramWriteData;
    logic [DW-1:0] ramDataA, ramDataB;
    logic [AW-1:0] ramAddrA, ramAddrB;

    int passed = 0;
    int total  = 0;

    dual_port_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clockPulse(clockPulse), .resetN(resetN),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .grant0(grant0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .grant1(grant1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ramWriteEnable(ramWriteEnable), .ramAddrA(ramAddrA), .ramAddrB(ramAddrB),
        .ramWriteData(ramWriteData), .ramDataA(ramDataA), .ramDataB(ramDataB)
    );

    always #5 clockPulse = ~clockPulse;

    // RAM macro: one-cycle registered read on both ports, write on port A.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clockPulse) begin
        if (ramWriteEnable) ram[ramAddrA] <= ramWriteData;
        ramDataA <= ram[ramAddrA];
        ramDataB <= ram[ramAddrB];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: memory contents as implied by the granted client ops.
    typedef struct { logic [DW-1:0] data; int due; } pend_t;
    logic [DW-1:0] ref_mem [2**AW];
    pend_t q0[$], q1[$];
    int    cyc = 0;
    logic  pg0 = 1'b0, pg1 = 1'b0;

    task automatic monitor_step();
        pend_t p;
        cyc++;
        if (!resetN) begin
            q0.delete(); q1.delete();
            pg0 = 1'b0; pg1 = 1'b0;
            return;
        end
        if (grant0) begin
            check("grant0_has_req", 32'(req0), 32'd1);
            check("grant0_gap", 32'(pg0), 32'd0);
        end
        if (grant1) begin
            check("grant1_has_req", 32'(req1), 32'd1);
            check("grant1_gap", 32'(pg1), 32'd0);
        end
        if (grant0 && grant1) begin
            check("cogrant_two_writes", 32'(we0 && we1), 32'd0);
            check("cogrant_hazard", 32'((we0 != we1) && (addr0 == addr1)), 32'd0);
        end
        if (grant0 && we0) begin
            check("wr0_strobe", {ramWriteEnable, ramAddrA, ramWriteData}, {1'b1, addr0, wdata0});
            ref_mem[addr0] = wdata0;
        end
        if (grant1 && we1) begin
            check("wr1_strobe", {ramWriteEnable, ramAddrA, ramWriteData}, {1'b1, addr1, wdata1});
            ref_mem[addr1] = wdata1;
        end
        if (!(grant0 && we0) && !(grant1 && we1))
            check("we_idle", 32'(ramWriteEnable), 32'd0);
        if (grant0 && !we0) begin
            check("rd0_port", 32'((ramAddrB == addr0) || (!ramWriteEnable && ramAddrA == addr0)), 32'd1);
            p.data = ref_mem[addr0]; p.due = cyc + RL + 1; q0.push_back(p);
        end
        if (grant1 && !we1) begin
            check("rd1_port", 32'((ramAddrB == addr1) || (!ramWriteEnable && ramAddrA == addr1)), 32'd1);
            p.data = ref_mem[addr1]; p.due = cyc + RL + 1; q1.push_back(p);
        end
        if (rvalid0) begin
            if (q0.size() == 0) check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
            else begin
                p = q0.pop_front();
                check("rvalid0_latency", cyc, p.due);
                check("rdata0", 32'(rdata0), 32'(p.data));
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            check("rvalid0_missing", 32'(rvalid0), 32'd1);
            p = q0.pop_front();
        end
        if (rvalid1) begin
            if (q1.size() == 0) check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
            else begin
                p = q1.pop_front();
                check("rvalid1_latency", cyc, p.due);
                check("rdata1", 32'(rdata1), 32'(p.data));
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            check("rvalid1_missing", 32'(rvalid1), 32'd1);
            p = q1.pop_front();
        end
        pg0 = grant0;
        pg1 = grant1;
    endtask

    initial forever begin
        @(negedge clockPulse);
        monitor_step();
    end

    task automatic drive(input int c, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (c == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Entered and left just after a falling edge.
    task automatic read_expect(input int c, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int   n = 0, g = -1;
        logic rv = 1'b0;
        drive(c, 1'b1, 1'b0, a, '0);
        while (n < 10 && g < 0) begin
            @(negedge clockPulse); n++;
            if ((c == 0) ? grant0 : grant1) g = n;
        end
        #1 drive(c, 1'b0, 1'b0, a, '0);
        check($sformatf("rd_c%0d_a%0d_granted", c, a), 32'(g > 0), 32'd1);
        while (n < 20 && !rv) begin
            @(negedge clockPulse); n++;
            rv = (c == 0) ? rvalid0 : rvalid1;
        end
        check($sformatf("rd_c%0d_a%0d_latency", c, a), n - g, RL + 1);
        check($sformatf("rd_c%0d_a%0d_data", c, a), 32'((c == 0) ? rdata0 : rdata1), 32'(exp));
        #1;
    endtask

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic g0, g1, we; logic [AW-1:0] ea, eb;
    } vec_t;
    vec_t vecs [12];

    initial begin
        int   gseq[$];
        int   i0, i1, guard, cnt;
        logic ok;

        vecs[0]  = '{1, 1, 6'd4,  16'hB0CB, 0, 0, 6'd0,  16'h0,    1, 0, 1, 6'd4,  6'd0};
        vecs[1]  = '{1, 0, 6'd4,  16'h0,    0, 0, 6'd0,  16'h0,    1, 0, 0, 6'd4,  6'd0};
        vecs[2]  = '{1, 0, 6'd4,  16'h0,    1, 0, 6'd11, 16'h0,    1, 1, 0, 6'd4,  6'd11};
        vecs[3]  = '{1, 1, 6'd20, 16'h1111, 1, 1, 6'd21, 16'h2222, 1, 0, 1, 6'd20, 6'd11};
        vecs[4]  = '{1, 1, 6'd22, 16'h3333, 1, 1, 6'd23, 16'h4444, 0, 1, 1, 6'd23, 6'd11};
        vecs[5]  = '{1, 0, 6'd7,  16'h0,    1, 1, 6'd8,  16'h0808, 1, 1, 1, 6'd8,  6'd7};
        vecs[6]  = '{0, 0, 6'd0,  16'h0,    1, 0, 6'd30, 16'h0,    0, 1, 0, 6'd30, 6'd7};
        vecs[7]  = '{1, 0, 6'd5,  16'h0,    1, 1, 6'd5,  16'h5555, 0, 1, 1, 6'd5,  6'd7};
        vecs[8]  = '{1, 1, 6'd40, 16'hAAAA, 1, 1, 6'd41, 16'hBBBB, 1, 0, 1, 6'd40, 6'd7};
        vecs[9]  = '{0, 0, 6'd0,  16'h0,    0, 0, 6'd0,  16'h0,    0, 0, 0, 6'd40, 6'd7};
        vecs[10] = '{1, 0, 6'd9,  16'h0,    1, 0, 6'd9,  16'h0,    1, 1, 0, 6'd9,  6'd9};
        vecs[11] = '{1, 1, 6'd13, 16'hDDDD, 1, 1, 6'd12, 16'hCCCC, 0, 1, 1, 6'd12, 6'd9};

        for (int i = 0; i < 2**AW; i++) begin
            ram[i]     = 16'(16'h1000 + i);
            ref_mem[i] = 16'(16'h1000 + i);
        end

        resetN = 1'b0;
        repeat (2) @(negedge clockPulse);
        check("reset_ctl", 32'({grant0, grant1, rvalid0, rvalid1, ramWriteEnable}), 32'd0);
        check("reset_addr", 32'({ramAddrA, ramAddrB}), 32'd0);
        check("reset_data", {rdata0, rdata1}, 32'(ramWriteData));
        #1 resetN = 1'b1;
        @(negedge clockPulse); #1;

        for (int k = 0; k < 12; k++) begin
            drive(0, vecs[k].r0, vecs[k].w0, vecs[k].a0, vecs[k].d0);
            drive(1, vecs[k].r1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
            @(negedge clockPulse);
            check($sformatf("v%0d_grant0", k), 32'(grant0), 32'(vecs[k].g0));
            check($sformatf("v%0d_grant1", k), 32'(grant1), 32'(vecs[k].g1));
            check($sformatf("v%0d_we", k), 32'(ramWriteEnable), 32'(vecs[k].we));
            check($sformatf("v%0d_addrA", k), 32'(ramAddrA), 32'(vecs[k].ea));
            check($sformatf("v%0d_addrB", k), 32'(ramAddrB), 32'(vecs[k].eb));
            #1 drive(0, 1'b0, 1'b0, '0, '0);
            drive(1, 1'b0, 1'b0, '0, '0);
            repeat (3) @(negedge clockPulse);
            #1;
        end

        // Reset while a read is in flight: nothing may come back.
        drive(0, 1'b1, 1'b0, 6'd4, '0);
        @(negedge clockPulse);
        check("rst_mid_grant0", 32'(grant0), 32'd1);
        #1 drive(0, 1'b0, 1'b0, '0, '0);
        resetN = 1'b0;
        #1;
        check("rst_mid_ctl", 32'({grant0, grant1, rvalid0, rvalid1, ramWriteEnable}), 32'd0);
        check("rst_mid_addr", 32'({ramAddrA, ramAddrB}), 32'd0);
        check("rst_mid_rdata", {rdata0, rdata1}, 32'(ramWriteData));
        @(negedge clockPulse); #1 resetN = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clockPulse);
            if (rvalid0) cnt++;
        end
        check("rst_mid_no_rvalid0", cnt, 0);
        #1;

        read_expect(0, 6'd4, 16'hB0CB);

        // Back-to-back writes from both clients to the same addresses.
        drive(0, 1'b1, 1'b1, 6'd50, 16'hC000);
        drive(1, 1'b1, 1'b1, 6'd50, 16'hD000);
        i0 = 0; i1 = 0; guard = 0;
        while ((i0 < 4 || i1 < 4) && guard < 40) begin
            @(negedge clockPulse); guard++;
            if (grant0 || grant1) gseq.push_back((grant0 && grant1) ? 2 : (grant0 ? 0 : 1));
            ok = grant0;
            #1;
            if (ok) begin
                i0++;
                if (i0 < 4) drive(0, 1'b1, 1'b1, 6'(50 + i0), 16'(16'hC000 + i0));
                else        drive(0, 1'b0, 1'b0, '0, '0);
            end
            if (grant1) begin
                i1++;
                if (i1 < 4) drive(1, 1'b1, 1'b1, 6'(50 + i1), 16'(16'hD000 + i1));
                else        drive(1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("rr_done", 32'(i0 == 4 && i1 == 4), 32'd1);
        check("rr_grant_count", gseq.size(), 8);
        for (int k = 0; k < gseq.size(); k++)
            check($sformatf("rr_order_%0d", k), gseq[k], k % 2);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clockPulse);
        #1;

        drive(0, 1'b1, 1'b1, 6'd60, 16'h6060);
        drive(1, 1'b1, 1'b1, 6'd61, 16'h6161);
        @(negedge clockPulse);
        check("rr_second_conflict", 32'({grant0, grant1}), 32'b01);
        #1 drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clockPulse);
        #1;
        for (int k = 0; k < 4; k++) read_expect(0, 6'(50 + k), 16'(16'hD000 + k));

        // Same-address write/read hazard: write first, read one edge later sees new data.
        drive(0, 1'b1, 1'b1, 6'd7, 16'h381C);
        drive(1, 1'b1, 1'b0, 6'd7, '0);
        @(negedge clockPulse);
        check("haz_first", 32'({grant1, grant0}), 32'b01);
        #1 drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clockPulse);
        check("haz_second", 32'({grant1, grant0}), 32'b10);
        #1 drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clockPulse);
        check("haz_rvalid1", 32'(rvalid1), 32'd1);
        check("haz_rdata1", 32'(rdata1), 32'h381C);
        #1;

        // Randomized traffic on a small address window to provoke conflicts.
        for (int t = 0; t < 400; t++) begin
            @(negedge clockPulse); #1;
            for (int c = 0; c < 2; c++) begin
                logic g, r;
                g = (c == 0) ? grant0 : grant1;
                r = (c == 0) ? req0 : req1;
                if (g || !r) begin
                    if ($urandom_range(0, 2) != 0)
                        drive(c, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom));
                    else
                        drive(c, 1'b0, 1'b0, '0, '0);
                end else if ($urandom_range(0, 15) == 0) begin
                    drive(c, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (6) @(negedge clockPulse);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
